// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch PC owner, instruction-bus requester and F/D holding
// register for the MIPS core. Captured words are offered to Decode with a
// valid/ready handshake; branch/jump/exception redirects may arrive at any
// time, including while a bus transaction is still outstanding.
//
// Build option: define PC_ADEL_CHECK_EN to turn a misaligned fetch PC into an
// address-error bubble (d_adel=1) instead of a bus request. Without it, d_adel
// is tied low and the low two address bits are forced to zero on the bus.
//
// Handshakes:
//   ibus   : fetch_req/fetch_addr are held until the cycle fetch_ok is seen;
//            fetch_ok may arrive in the same cycle as the first request.
//   decode : d_valid/d_pc/d_instr are registered and held while d_valid=1 and
//            d_ready=0; the word is transferred in a cycle with both high. A
//            redirect in HOLD withdraws an unaccepted word.
`default_nettype none

module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_ok,
    input  logic [31:0] fetch_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [31:0] d_pc,
    output logic [31:0] d_instr,
    output logic        d_adel,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // one bubble after reset before the first request
        REQ  = 2'd1,   // request outstanding for pc_q
        DROP = 2'd2,   // request outstanding, but its word is stale (redirected)
        HOLD = 2'd3    // captured word offered to Decode
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pend_q;
    logic [31:0] pend_d;
    logic        load_word;
    logic        d_valid_q;
    logic [31:0] d_pc_q;
    logic [31:0] d_instr_q;

`ifdef PC_ADEL_CHECK_EN
    logic        misaligned;
    logic        load_adel;
    logic        d_adel_q;

    assign misaligned = (pc_q[1:0] != 2'b00);
`endif

    // State register, the only place the FSM state is updated
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, PC/pending-target update and bus request decode
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_d    = pend_q;
        load_word = 1'b0;
        fetch_req = 1'b0;
`ifdef PC_ADEL_CHECK_EN
        load_adel = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                state_d = REQ;
            end

            REQ: begin
`ifdef PC_ADEL_CHECK_EN
                if (misaligned) begin
                    // No bus cycle for a bad PC; a redirect in the same cycle
                    // takes precedence over raising the fault.
                    if (redirect_valid) begin
                        pc_d = redirect_pc;
                    end else begin
                        load_adel = 1'b1;
                        state_d   = HOLD;
                    end
                end else begin
`endif
                    fetch_req = 1'b1;
                    if (fetch_ok) begin
                        if (redirect_valid) begin
                            // Word arrived but is already on the wrong path.
                            pc_d = redirect_pc;
                        end else begin
                            load_word = 1'b1;
                            pc_d      = pc_q + PC_STEP;
                            state_d   = HOLD;
                        end
                    end else if (redirect_valid) begin
                        // Bus address must stay put until the response, so
                        // park the target and throw the response away later.
                        pend_d  = redirect_pc;
                        state_d = DROP;
                    end
`ifdef PC_ADEL_CHECK_EN
                end
`endif
            end

            DROP: begin
                fetch_req = 1'b1;
                if (fetch_ok) begin
                    pc_d    = redirect_valid ? redirect_pc : pend_q;
                    state_d = REQ;
                end else if (redirect_valid) begin
                    pend_d = redirect_pc;
                end
            end

            HOLD: begin
                if (redirect_valid) begin
                    // Accepted or not, the next fetch comes from the target.
                    pc_d    = redirect_pc;
                    state_d = REQ;
                end else if (d_ready) begin
                    state_d = REQ;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Fetch PC and pending redirect target
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc_q   <= RESET_PC;
            pend_q <= 32'h0;
        end else begin
            pc_q   <= pc_d;
            pend_q <= pend_d;
        end
    end

    // F/D holding register: d_valid follows HOLD, payload loads on capture
    always_ff @(posedge clk) begin
        if (!resetn) begin
            d_valid_q <= 1'b0;
            d_pc_q    <= 32'h0;
            d_instr_q <= 32'h0;
        end else begin
            d_valid_q <= (state_d == HOLD);
            if (load_word) begin
                d_pc_q    <= pc_q;
                d_instr_q <= fetch_instr;
            end
`ifdef PC_ADEL_CHECK_EN
            if (load_adel) begin
                d_pc_q    <= pc_q;
                d_instr_q <= 32'h0;
            end
`endif
        end
    end

`ifdef PC_ADEL_CHECK_EN
    // Address-error flag travels with the offered bubble only
    always_ff @(posedge clk) begin
        if (!resetn) begin
            d_adel_q <= 1'b0;
        end else if (load_adel) begin
            d_adel_q <= 1'b1;
        end else if (load_word || (state_d != HOLD)) begin
            d_adel_q <= 1'b0;
        end
    end

    assign d_adel     = d_adel_q;
    assign fetch_addr = pc_q;
`else
    assign d_adel     = 1'b0;
    assign fetch_addr = {pc_q[31:2], 2'b00};
`endif

    assign d_valid   = d_valid_q;
    assign d_pc      = d_pc_q;
    assign d_instr   = d_instr_q;
    assign state_dbg = state_q;

`ifndef SYNTHESIS
    // Bus address never moves while a request waits for its response.
    addr_stable_a: assert property (@(posedge clk)
        (resetn && fetch_req && !fetch_ok) |=> (!resetn || $stable(fetch_addr)));

    // An unaccepted, non-withdrawn offer stays exactly as it was.
    offer_stable_a: assert property (@(posedge clk)
        (resetn && d_valid && !d_ready && !redirect_valid) |=>
            (!resetn || (d_valid && $stable(d_pc) && $stable(d_instr))));
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: table-driven directed test of fetch_sequencer. Each table
// row gives the inputs for one cycle and the outputs expected during that
// cycle; a few hand-written sequences cover the misaligned-PC path and reset
// while an offer is stalled.
`default_nettype none

module tb_fetch_sequencer;

    typedef struct {
        logic        chk;
        logic        resetn;
        logic        ok;
        logic [31:0] instr;
        logic        rv;
        logic [31:0] rpc;
        logic        dr;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_dv;
        logic [31:0] e_dpc;
        logic [31:0] e_dinstr;
    } vec_t;

    // ---------------- clock / reset / DUT ----------------
    logic        clk;
    logic        resetn;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ok;
    logic [31:0] fetch_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic        d_adel;
    logic [1:0]  state_dbg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk            (clk),
        .resetn         (resetn),
        .fetch_req      (fetch_req),
        .fetch_addr     (fetch_addr),
        .fetch_ok       (fetch_ok),
        .fetch_instr    (fetch_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .d_valid        (d_valid),
        .d_ready        (d_ready),
        .d_pc           (d_pc),
        .d_instr        (d_instr),
        .d_adel         (d_adel),
        .state_dbg      (state_dbg)
    );

    // ---------------- scoreboard counters ----------------
    int   tests_run;
    int   failures;
    vec_t vecs[$];

    task automatic check(input string name, input int step,
                         input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, step, act, exp);
        end
    endtask

    function automatic void add(input logic chk, input logic rst, input logic ok,
                                input logic [31:0] instr, input logic rv,
                                input logic [31:0] rpc, input logic dr,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_dv, input logic [31:0] e_dpc,
                                input logic [31:0] e_dinstr);
        vec_t v;
        v.chk = chk; v.resetn = rst; v.ok = ok; v.instr = instr;
        v.rv = rv; v.rpc = rpc; v.dr = dr;
        v.e_req = e_req; v.e_addr = e_addr; v.e_dv = e_dv;
        v.e_dpc = e_dpc; v.e_dinstr = e_dinstr;
        vecs.push_back(v);
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic rst, input logic ok, input logic [31:0] instr,
                         input logic rv, input logic [31:0] rpc, input logic dr);
        resetn         = rst;
        fetch_ok       = ok;
        fetch_instr    = instr;
        redirect_valid = rv;
        redirect_pc    = rpc;
        d_ready        = dr;
    endtask

    // Full output check for one cycle; payload only matters while offered.
    task automatic check_outputs(input int step, input logic e_req, input logic [31:0] e_addr,
                                 input logic e_dv, input logic [31:0] e_dpc,
                                 input logic [31:0] e_dinstr, input logic e_adel);
        check("fetch_req", step, {31'b0, fetch_req}, {31'b0, e_req});
        check("fetch_addr", step, fetch_addr, e_addr);
        check("d_valid", step, {31'b0, d_valid}, {31'b0, e_dv});
        check("d_adel", step, {31'b0, d_adel}, {31'b0, e_adel});
        if (e_dv) begin
            check("d_pc", step, d_pc, e_dpc);
            check("d_instr", step, d_instr, e_dinstr);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        tests_run = 0;
        failures  = 0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        //   chk rst ok instr         rv rpc           dr | req addr          dv dpc           dinstr
        // Reset, then first fetch answered two cycles after the request.
        add(0, 0, 0, 32'h0,        0, 32'h0,        0,   0, 32'h0,        0, 32'h0,        32'h0);
        add(1, 0, 0, 32'h0,        0, 32'h0,        0,   0, 32'hbfc00000, 0, 32'h0,        32'h0);
        add(1, 1, 0, 32'h0,        0, 32'h0,        0,   0, 32'hbfc00000, 0, 32'h0,        32'h0);
        add(1, 1, 0, 32'h0,        0, 32'h0,        0,   1, 32'hbfc00000, 0, 32'h0,        32'h0);
        add(1, 1, 0, 32'h0,        0, 32'h0,        0,   1, 32'hbfc00000, 0, 32'h0,        32'h0);
        add(1, 1, 1, 32'h24020001, 0, 32'h0,        1,   1, 32'hbfc00000, 0, 32'h0,        32'h0);
        add(1, 1, 0, 32'h0,        0, 32'h0,        1,   0, 32'hbfc00004, 1, 32'hbfc00000, 32'h24020001);
        // Same-cycle response, then Decode stalls five cycles.
        add(1, 1, 1, 32'h8c430000, 0, 32'h0,        0,   1, 32'hbfc00004, 0, 32'h0,        32'h0);
        for (int i = 0; i < 5; i++)
            add(1, 1, 0, 32'h0,    0, 32'h0,        0,   0, 32'hbfc00008, 1, 32'hbfc00004, 32'h8c430000);
        add(1, 1, 0, 32'h0,        0, 32'h0,        1,   0, 32'hbfc00008, 1, 32'hbfc00004, 32'h8c430000);
        // Redirect while the request is outstanding; stale word 3 cycles later.
        add(1, 1, 0, 32'h0,        1, 32'h80001000, 0,   1, 32'hbfc00008, 0, 32'h0,        32'h0);
        add(1, 1, 0, 32'h0,        0, 32'h0,        0,   1, 32'hbfc00008, 0, 32'h0,        32'h0);
        add(1, 1, 0, 32'h0,        0, 32'h0,        0,   1, 32'hbfc00008, 0, 32'h0,        32'h0);
        add(1, 1, 1, 32'hdeadbeef, 0, 32'h0,        0,   1, 32'hbfc00008, 0, 32'h0,        32'h0);
        // Redirect together with fetch_ok in REQ.
        add(1, 1, 1, 32'h0badf00d, 1, 32'h80002000, 0,   1, 32'h80001000, 0, 32'h0,        32'h0);
        // Three redirects while dropping: the last target wins.
        add(1, 1, 0, 32'h0,        1, 32'h80003000, 0,   1, 32'h80002000, 0, 32'h0,        32'h0);
        add(1, 1, 0, 32'h0,        1, 32'h80004000, 0,   1, 32'h80002000, 0, 32'h0,        32'h0);
        add(1, 1, 0, 32'h0,        1, 32'h80005000, 0,   1, 32'h80002000, 0, 32'h0,        32'h0);
        add(1, 1, 1, 32'h11111111, 0, 32'h0,        0,   1, 32'h80002000, 0, 32'h0,        32'h0);
        add(1, 1, 1, 32'h22222222, 0, 32'h0,        0,   1, 32'h80005000, 0, 32'h0,        32'h0);
        // Redirect withdraws an unaccepted offer; target is the top word.
        add(1, 1, 0, 32'h0,        1, 32'hfffffffc, 0,   0, 32'h80005004, 1, 32'h80005000, 32'h22222222);
        add(1, 1, 1, 32'h33333333, 0, 32'h0,        0,   1, 32'hfffffffc, 0, 32'h0,        32'h0);
        // PC wrapped to zero; redirect together with acceptance.
        add(1, 1, 0, 32'h0,        1, 32'h80000100, 1,   0, 32'h00000000, 1, 32'hfffffffc, 32'h33333333);
        // Enter DROP, then reset with the bus transaction in flight.
        add(1, 1, 0, 32'h0,        1, 32'h80000200, 0,   1, 32'h80000100, 0, 32'h0,        32'h0);
        add(1, 0, 0, 32'h0,        0, 32'h0,        0,   1, 32'h80000100, 0, 32'h0,        32'h0);
        add(1, 1, 1, 32'h66666666, 0, 32'h0,        0,   0, 32'hbfc00000, 0, 32'h0,        32'h0);
        // DROP resolved by a redirect in the same cycle as fetch_ok.
        add(1, 1, 0, 32'h0,        1, 32'h80000400, 0,   1, 32'hbfc00000, 0, 32'h0,        32'h0);
        add(1, 1, 1, 32'h77777777, 1, 32'h80000800, 0,   1, 32'hbfc00000, 0, 32'h0,        32'h0);
        add(1, 1, 1, 32'h44444444, 0, 32'h0,        0,   1, 32'h80000800, 0, 32'h0,        32'h0);
        add(1, 1, 0, 32'h0,        0, 32'h0,        1,   0, 32'h80000804, 1, 32'h80000800, 32'h44444444);
        add(1, 1, 0, 32'h0,        0, 32'h0,        0,   1, 32'h80000804, 0, 32'h0,        32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].resetn, vecs[i].ok, vecs[i].instr, vecs[i].rv, vecs[i].rpc, vecs[i].dr);
            #1;
            if (vecs[i].chk)
                check_outputs(i, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_dv,
                              vecs[i].e_dpc, vecs[i].e_dinstr, 1'b0);
        end

        // Misaligned redirect target (dut is in REQ at 80000804, idle bus).
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h0, 1'b1, 32'h80000002, 1'b0);
        #1;
        check_outputs(100, 1'b1, 32'h80000804, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
`ifdef PC_ADEL_CHECK_EN
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        check_outputs(101, 1'b0, 32'h80000002, 1'b0, 32'h0, 32'h0, 1'b0);
`else
        drive(1'b1, 1'b1, 32'h55555555, 1'b0, 32'h0, 1'b0);
        #1;
        check_outputs(101, 1'b1, 32'h80000000, 1'b0, 32'h0, 32'h0, 1'b0);
`endif
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h80000010, 1'b0);
        #1;
`ifdef PC_ADEL_CHECK_EN
        check_outputs(102, 1'b0, 32'h80000002, 1'b1, 32'h80000002, 32'h0, 1'b1);
`else
        check_outputs(102, 1'b0, 32'h80000004, 1'b1, 32'h80000002, 32'h55555555, 1'b0);
`endif
        @(negedge clk);
        drive(1'b1, 1'b1, 32'ha5a5a5a5, 1'b0, 32'h0, 1'b0);
        #1;
        check_outputs(103, 1'b1, 32'h80000010, 1'b0, 32'h0, 32'h0, 1'b0);

        // Reset while an offer is stalled in HOLD.
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        check_outputs(104, 1'b0, 32'h80000014, 1'b1, 32'h80000010, 32'ha5a5a5a5, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        check_outputs(105, 1'b0, 32'hbfc00000, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        #1;
        check_outputs(106, 1'b1, 32'hbfc00000, 1'b0, 32'h0, 32'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

`default_nettype wire
